ps2_host: RTL and testbench

Open-collector PS/2 host controller for the keyboard port. Receives device-to-host scan-code frames and sends host-to-device command bytes. Sits directly upstream of the two bidirectional pad buffers, one for PS/2 clock and one for PS/2 data. It drives each buffer's input and tristate-enable and consumes each buffer's output. It hands received bytes to the keyboard-matrix logic over a single-cycle valid strobe.

---
 rtl/ps2_host.sv | 148 ++++++++++++++
 tb/tb_ps2_host.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host.sv
// ps2_host: open-collector PS/2 host controller that receives scan-code frames and sends command bytes
module ps2_host #(
    parameter int FILTER_CYCLES  = 8,
    parameter int INHIBIT_CYCLES = 3200,
    parameter int TIMEOUT_CYCLES = 64000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_o,
    output logic       ps2_clk_t,
    input  logic       ps2_data_i,
    output logic       ps2_data_o,
    output logic       ps2_data_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);
    localparam logic [2:0] IDLE = 3'd0, RX = 3'd1, TX_INHIBIT = 3'd2, TX_REQ = 3'd3,
                           TX_BITS = 3'd4, TX_ACK = 3'd5, TX_WAIT = 3'd6;
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
    logic [1:0] clk_s, data_s;
    logic [FW-1:0] clk_fc, data_fc;
    logic clk_f, data_f, clk_fd;
    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [3:0] bits;
    logic [10:0] sh;
    logic tx_bit;
    logic fall, timeout;
    logic [10:0] rx_frame;
    logic rx_good;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s   <= 2'b11;
            data_s  <= 2'b11;
            clk_fc  <= '0;
            data_fc <= '0;
            clk_f   <= 1'b1;
            data_f  <= 1'b1;
            clk_fd  <= 1'b1;
        end else begin
            clk_s   <= {clk_s[0], ps2_clk_i};
            data_s  <= {data_s[0], ps2_data_i};
            clk_fd  <= clk_f;
            clk_fc  <= (clk_s[1] == clk_f || clk_fc == FW'(FILTER_CYCLES - 1)) ? '0 : clk_fc + 1'b1;
            data_fc <= (data_s[1] == data_f || data_fc == FW'(FILTER_CYCLES - 1)) ? '0 : data_fc + 1'b1;
            if (clk_s[1] != clk_f && clk_fc == FW'(FILTER_CYCLES - 1)) clk_f <= clk_s[1];
            if (data_s[1] != data_f && data_fc == FW'(FILTER_CYCLES - 1)) data_f <= data_s[1];
        end
    end
    assign fall     = clk_fd & ~clk_f;
    assign rx_frame = {data_f, sh[10:1]};
    assign rx_good  = ~rx_frame[0] & (^rx_frame[9:1]) & rx_frame[10];
    assign timeout  = state != IDLE && state != TX_INHIBIT && !fall && cnt == CW'(TIMEOUT_CYCLES);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            sh       <= '0;
            tx_bit   <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            // our own clock pull-down during inhibit must not restart the hold count
            cnt <= (state == IDLE || (fall && state != TX_INHIBIT)) ? '0 : (&cnt ? cnt : cnt + 1'b1);
            if (timeout) begin
                state    <= IDLE;
                rx_error <= state == RX;
                tx_error <= state != RX;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall && !data_f) begin
                            state <= RX;
                            bits  <= 4'd1;
                            sh    <= rx_frame;
                        end else if (tx_valid && tx_ready) begin
                            state  <= TX_INHIBIT;
                            sh     <= {2'b11, ~^tx_data, tx_data};
                            tx_bit <= 1'b0;
                        end
                    end
                    RX: begin
                        if (fall) begin
                            sh   <= rx_frame;
                            bits <= bits + 1'b1;
                            if (bits == 4'd10) begin
                                state    <= IDLE;
                                rx_valid <= rx_good;
                                rx_error <= !rx_good;
                                if (rx_good) rx_data <= rx_frame[8:1];
                            end
                        end
                    end
                    TX_INHIBIT: begin
                        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                            state <= TX_REQ;
                            cnt   <= '0;
                        end
                    end
                    TX_REQ: begin
                        state <= TX_BITS;
                        bits  <= '0;
                    end
                    TX_BITS: begin
                        if (fall) begin
                            tx_bit <= sh[0];
                            sh     <= sh >> 1;
                            bits   <= bits + 1'b1;
                            if (bits == 4'd9) state <= TX_ACK;
                        end
                    end
                    TX_ACK: begin
                        if (fall) begin
                            tx_done  <= !data_f;
                            tx_error <= data_f;
                            state    <= TX_WAIT;
                        end
                    end
                    TX_WAIT: if (clk_f && data_f) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign ps2_clk_o  = 1'b0;
    assign ps2_data_o = 1'b0;
    assign ps2_clk_t  = state != TX_INHIBIT;
    assign ps2_data_t = (state == TX_REQ || state == TX_BITS) ? tx_bit : 1'b1;
    assign tx_ready   = state == IDLE && !fall;
    assign busy       = state != IDLE;
endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: open-collector line model with a PS/2 device driving ps2_host frames both ways
module tb_ps2_host;
    localparam int F = 8, INH = 320, TO = 3000, HALF = 40;
    logic clk = 1'b0, reset_n = 1'b0;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic ps2_clk_i, ps2_clk_o, ps2_clk_t, ps2_data_i, ps2_data_o, ps2_data_t;
    logic [7:0] rx_data, tx_data = 8'h00;
    logic rx_valid, rx_error, tx_valid = 1'b0, tx_ready, tx_done, tx_error, busy;
    int total = 0, bad = 0;
    int n_rv = 0, n_re = 0, n_td = 0, n_te = 0;
    logic [7:0] last_good;

    typedef struct {
        logic [7:0] d;
        logic       flip;
        logic       bad_stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } rx_vec_t;
    rx_vec_t tab[6];

    always #5 clk = ~clk;
    assign ps2_clk_i  = dev_clk & ps2_clk_t;
    assign ps2_data_i = dev_data & ps2_data_t;

    ps2_host #(.FILTER_CYCLES(F), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ps2_clk_i(ps2_clk_i), .ps2_clk_o(ps2_clk_o), .ps2_clk_t(ps2_clk_t),
        .ps2_data_i(ps2_data_i), .ps2_data_o(ps2_data_o), .ps2_data_t(ps2_data_t),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_error(tx_error), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid) n_rv++;
        if (rx_error) n_re++;
        if (tx_done) n_td++;
        if (tx_error) n_te++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            dev_data = fr[i];
            cyc(HALF);
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic rx_case(input logic [10:0] fr, input logic exp_v, input logic [7:0] exp_d, input string tag);
        int v0, e0;
        v0 = n_rv;
        e0 = n_re;
        send(fr, 11);
        chk({tag, "_valid"}, n_rv - v0, exp_v);
        chk({tag, "_error"}, n_re - e0, !exp_v);
        chk({tag, "_data"}, rx_data, exp_d);
    endtask

    task automatic tx_case(input logic [7:0] d, input logic ack, input string tag);
        logic [9:0] seen, exp;
        int n, d0, e0;
        d0 = n_td;
        e0 = n_te;
        seen = '0;
        exp = {1'b1, ($countones(d) % 2 == 0), d};
        @(negedge clk);
        chk({tag, "_ready_before"}, tx_ready, 1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk({tag, "_ready_after_accept"}, tx_ready, 0);
        n = 0;
        while (!ps2_clk_t && n < INH + 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_inhibit_len"}, n, INH);
        chk({tag, "_data_low_at_release"}, ps2_data_t, 0);
        cyc(20);
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            if (i < 10) seen[i] = ps2_data_i;
            if (i == 9 && ack) dev_data = 1'b0;
            cyc(HALF);
        end
        chk({tag, "_bits_seen"}, seen, exp);
        chk({tag, "_done"}, n_td - d0, ack);
        chk({tag, "_error"}, n_te - e0, !ack);
        if (ack) chk({tag, "_ready_held"}, tx_ready, 0);
        dev_data = 1'b1;
        n = 0;
        while (!tx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready_return"}, tx_ready, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] fr;
        logic [7:0] d;
        int v0, e0, n, sel, busy_seen;
        tab[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C};
        tab[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h1C};
        tab[2] = '{8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA};
        tab[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'hAA};
        tab[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        tab[5] = '{8'hF0, 1'b1, 1'b0, 1'b0, 8'h00};
        cyc(3);
        chk("reset_clk_t", ps2_clk_t, 1);
        chk("reset_data_t", ps2_data_t, 1);
        reset_n = 1'b1;
        cyc(2);
        chk("reset_clk_o", ps2_clk_o, 0);
        chk("reset_data_o", ps2_data_o, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", n_rv + n_re + n_td + n_te, 0);

        for (int i = 0; i < 6; i++) begin
            fr = {~tab[i].bad_stop, (~^tab[i].d) ^ tab[i].flip, tab[i].d, 1'b0};
            rx_case(fr, tab[i].exp_valid, tab[i].exp_data, $sformatf("rx_tab%0d", i));
        end
        last_good = tab[5].exp_data;

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            sel = int'($urandom_range(0, 3));
            fr[0] = 1'b0;
            fr[8:1] = d;
            fr[9] = ($countones(d) % 2 == 0) ^ (sel == 0);
            fr[10] = sel != 1;
            if (fr[0] == 1'b0 && $countones(fr[9:1]) % 2 == 1 && fr[10]) last_good = d;
            rx_case(fr, fr[10] && sel != 0, last_good, $sformatf("rx_rand%0d", i));
        end

        tx_case(8'hFF, 1'b1, "tx_ff_ack");
        tx_case(8'hFF, 1'b0, "tx_ff_nack");
        for (int i = 0; i < 3; i++)
            tx_case(8'($urandom), 1'($urandom), $sformatf("tx_rand%0d", i));

        v0 = n_rv;
        e0 = n_re;
        fr = {1'b1, 1'b1, 8'hAA, 1'b0};
        for (int i = 0; i < 5; i++) begin
            dev_data = fr[i];
            cyc(HALF);
            dev_clk = 1'b0;
            if (i < 4) begin
                cyc(HALF);
                dev_clk = 1'b1;
            end
        end
        n = HALF;
        cyc(HALF);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        while (!rx_error && n < TO + 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_timeout_window", (n >= TO + F && n <= TO + F + 8), 1);
        cyc(5);
        chk("rx_timeout_error", n_re - e0, 1);
        chk("rx_timeout_valid", n_rv - v0, 0);
        rx_case({1'b1, 1'b1, 8'hAA, 1'b0}, 1'b1, 8'hAA, "rx_recover");

        v0 = n_rv + n_re + n_td + n_te;
        busy_seen = 0;
        dev_clk = 1'b0;
        cyc(3);
        dev_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || !tx_ready) busy_seen++;
        end
        chk("glitch_busy", busy_seen, 0);
        chk("glitch_strobes", n_rv + n_re + n_td + n_te - v0, 0);

        @(negedge clk);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc(50);
        chk("mid_inhibit_clk_t", ps2_clk_t, 0);
        reset_n = 1'b0;
        #1;
        chk("reset_async_clk_t", ps2_clk_t, 1);
        chk("reset_async_data_t", ps2_data_t, 1);
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        chk("post_reset_ready", tx_ready, 1);
        chk("post_reset_rx_data", rx_data, 8'h00);
        chk("post_reset_strobes", n_rv + n_re + n_td + n_te - v0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
